// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer states, frame constants and baud divisor math.
// Used by both the buffered transmitter and the matching receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Clock cycles per bit, rounded to nearest.
  function automatic int calc_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; head entry is readable combinationally
// so a consumer can load it on the same edge that pops it.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             push_en;
  logic             pop_en;

  // A push while full is dropped even if a pop happens on the same edge.
  assign push_en  = push && !full;
  assign pop_en   = pop && !empty;
  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push_en && !pop_en) begin
      count_d = count_q + 1'b1;
    end else if (!push_en && pop_en) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 transmitter: host bytes queue in a FIFO and are shifted out LSB-first
// on a registered txd line, back-to-back while the queue is non-empty.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_done
);

  localparam int DIV    = calc_div(CLK_FREQ, BAUD);
  localparam int BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
  localparam logic [BIT_W-1:0]  LAST_DATA = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  LAST_STOP = BIT_W'(STOP_BITS - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_buffered: CLK_FREQ/BAUD must give at least 2 cycles per bit");
  end

  tx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              txd_q, txd_d;

  logic              fifo_pop;
  logic [7:0]        fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              baud_last;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_valid),
    .push_data (wr_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign wr_ready  = !fifo_full;
  assign txd       = txd_q;
  assign busy      = (state_q != IDLE) || !fifo_empty;
  assign baud_last = (baud_q == BAUD_LAST);
  assign tx_done   = (state_q == STOP) && baud_last && (bit_q == LAST_STOP);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    txd_d    = txd_q;
    fifo_pop = 1'b0;

    case (state_q)
      IDLE: begin
        txd_d  = 1'b1;
        baud_d = '0;
        bit_d  = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          state_d  = START;
          txd_d    = 1'b0;
        end
      end

      START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
          txd_d   = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == LAST_DATA) begin
            bit_d   = '0;
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            // txd takes the bit that lands in position 0 after this shift.
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == LAST_STOP) begin
            bit_d = '0;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shift_d  = fifo_head;
              state_d  = START;
              txd_d    = 1'b0;
            end else begin
              state_d = IDLE;
              txd_d   = 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

endmodule
